sha256_block_feeder: RTL and testbench
======================================

# sha256_block_feeder

Producer side of the SHA-256 core's block interface. It accepts a message as a byte stream with a declared byte length and applies standard SHA-256 padding: 0x80, zero fill, and a 64-bit big-endian bit length. It presents each 512-bit block on `message` together with the total block count on `block`, and advances to the next block when the core pulses `next_block_read_rdy`. It sits between the host/byte source and the `sha256` core in the top level.

## Interface
- No parameters; all widths are fixed by the core interface.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a new message; sampled only in IDLE.
- `msg_len` in 32: message length in bytes; sampled with `start`.
- `in_data` in 8: message byte, in stream order.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the feeder accepts `in_data` this cycle; a transfer occurs when `in_valid && in_ready`.
- `message` out 512: current block, big-endian; block byte 0 at [511:504], byte 63 at [7:0].
- `block` out 64: total blocks for the message, equal to floor((msg_len+8)/64)+1; held stable from the cycle after `start` until `done`.
- `blk_valid` out 1: `message` holds a complete block.
- `next_block_read_rdy` in 1: one-cycle pulse from the core meaning "current block consumed".
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse after the final block is consumed.

## Operation
- States: IDLE, FILL, HOLD.
- IDLE:
  - On `start`, latch `msg_len` into `rem` (32b) and `bitlen = msg_len*8` (64b, zero-extended).
  - Compute `block`; clear `idx` (6b), `blk_cnt` (64b) and `pad_started`; go to FILL.
- FILL writes one byte per cycle at block byte `idx`, with this source priority:
  - If `rem != 0`: input byte, written only on a transfer, which also decrements `rem`.
  - Else if `!pad_started`: 0x80, and set `pad_started`.
  - Else if `blk_cnt == block-1` and `idx >= 56`: length byte `bitlen[8*(63-idx)+7 -: 8]`.
  - Else: 0x00.
- `in_ready = (state==FILL) && (rem != 0)`. Pad and length bytes need no input and take one cycle each.
- After byte 63 is written, go to HOLD with `blk_valid=1`.
  - `idx` wraps to 0.
  - The 0x80 byte may land in a non-final block (msg_len mod 64 in 56..63); that block is then zero-filled, and the final block holds only zeros plus the length.
- HOLD:
  - `message` is stable and `in_ready=0`.
  - On `next_block_read_rdy`: increment `blk_cnt` and drop `blk_valid`.
  - If `blk_cnt+1 == block`: pulse `done`, go to IDLE. Otherwise go to FILL.
- `next_block_read_rdy` outside HOLD is ignored.
- `start` outside IDLE is ignored.
- Input bytes beyond `msg_len` are never accepted.

## Timing
- Reset values: `in_ready=0`, `blk_valid=0`, `busy=0`, `done=0`, `message=0`, `block=0`, state IDLE.
- Reset mid-operation aborts the message; a partially filled block is discarded.
- `start` in cycle T: `busy=1` and `block` valid at T+1; `in_ready=1` at T+1 if `msg_len>0`.
- A block with continuous `in_valid` takes exactly 64 FILL cycles; `blk_valid` rises the cycle after byte 63 is written.
- `next_block_read_rdy` in cycle R:
  - `blk_valid=0` at R+1.
  - FILL resumes at R+1, or `done=1` at R+1 with `busy` dropping at R+2.
- No double buffering: FILL never overlaps HOLD.
- Gaps in `in_valid` stall FILL with no byte written. Pad bytes never stall.
- `next_block_read_rdy` in the same cycle that HOLD is entered is ignored; only HOLD-state cycles count.

## Test plan
- **"abc" (len 3):**
  - `block=1`.
  - `message = 0x61626380` followed by zeros, with [63:0] = 0x18.
  - `blk_valid` 64 cycles after the first byte.
  - On `next_block_read_rdy`: `done` pulse, then `busy=0`.
- **len 0:** `block=1`; `in_ready` never rises; `message` = 0x80 at [511:504], all other bits 0.
- **len 56, bytes 0x00..0x37:**
  - `block=2`.
  - Block 0: bytes 0..55 = data, byte 56 = 0x80, bytes 57..63 = 0.
  - Block 1: zeros, with [63:0] = 0x1C0.
- **len 64:** `block=2`; block 0 = data; block 1 = 0x80, zeros, [63:0] = 0x200.
- **Stalls (len 70):**
  - Random `in_valid` gaps; `next_block_read_rdy` delayed 20 cycles.
  - `message` stable and `in_ready=0` throughout HOLD.
  - Stray `next_block_read_rdy` pulses during FILL are ignored.
  - Spurious `start` while busy is ignored.
- **Reset mid-FILL (after 30 of 100 bytes):**
  - All outputs at reset values the next cycle.
  - A following "abc" message produces the correct single block.

Source files
------------

// File: rtl/sha256_block_feeder.sv
// Producer side of the SHA-256 block interface: streams message bytes into
// 512-bit blocks, appends standard padding and hands each block to the core.
module sha256_block_feeder (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  msg_len,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] message,
  output logic [63:0]  block,
  output logic         blk_valid,
  input  logic         next_block_read_rdy,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] rem;
  logic [63:0] bitlen;
  logic [63:0] blk_cnt;
  logic [5:0]  idx;
  logic        pad_started;

  logic        byte_we;
  logic [7:0]  byte_val;
  logic        last_blk;
  logic [7:0]  len_byte;

  assign last_blk  = (blk_cnt == block - 64'd1);
  // Length bytes occupy idx 56..63, most significant byte first.
  assign len_byte  = 8'(bitlen >> {3'd7 - idx[2:0], 3'b000});
  assign in_ready  = (state == FILL) && (rem != 32'd0);
  assign blk_valid = (state == HOLD);
  assign busy      = (state != IDLE) || done;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_next = state;
    byte_we    = 1'b0;
    byte_val   = 8'h00;
    case (state)
      IDLE: if (start) state_next = FILL;
      FILL: begin
        if (rem != 32'd0) begin
          byte_we  = in_valid;
          byte_val = in_data;
        end else if (!pad_started) begin
          byte_we  = 1'b1;
          byte_val = 8'h80;
        end else if (last_blk && idx >= 6'd56) begin
          byte_we  = 1'b1;
          byte_val = len_byte;
        end else begin
          byte_we  = 1'b1;
        end
        if (byte_we && idx == 6'd63) state_next = HOLD;
      end
      HOLD: begin
        if (next_block_read_rdy)
          state_next = (blk_cnt + 64'd1 == block) ? IDLE : FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the block register is cleared on reset too, since message=0 is a visible reset value.
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      bitlen      <= '0;
      block       <= '0;
      blk_cnt     <= '0;
      idx         <= '0;
      pad_started <= 1'b0;
      message     <= '0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem         <= msg_len;
            bitlen      <= {29'd0, msg_len, 3'd0};
            block       <= (({32'd0, msg_len} + 64'd8) >> 6) + 64'd1;
            blk_cnt     <= '0;
            idx         <= '0;
            pad_started <= 1'b0;
          end
        end
        FILL: begin
          if (byte_we) begin
            // Byte idx lands at bit 8*(63-idx); ~idx equals 63-idx for a 6-bit index.
            message[{~idx, 3'b000} +: 8] <= byte_val;
            idx <= idx + 6'd1;
            if (rem != 32'd0) rem <= rem - 32'd1;
            else              pad_started <= 1'b1;
          end
        end
        HOLD: begin
          if (next_block_read_rdy) begin
            blk_cnt <= blk_cnt + 64'd1;
            done    <= (blk_cnt + 64'd1 == block);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Randomised bench for sha256_block_feeder against a byte-queue padding model.
module tb_sha256_block_feeder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  msg_len = '0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] message;
  logic [63:0]  block;
  logic         blk_valid;
  logic         next_block_read_rdy = 1'b0;
  logic         busy;
  logic         done;

  int ntotal = 0;
  int nbad   = 0;

  logic [7:0]   msg_bytes[$];
  logic [7:0]   padded[$];
  logic [511:0] got_blocks[$];
  logic [63:0]  got_block_cnt;

  always #5 clk = ~clk;

  sha256_block_feeder dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .message(message), .block(block), .blk_valid(blk_valid),
    .next_block_read_rdy(next_block_read_rdy), .busy(busy), .done(done)
  );

  // Reference padding: data, 0x80, zeros to 56 mod 64, then 64-bit bit length.
  function automatic void build_model();
    logic [63:0] bl;
    bl = 64'(msg_bytes.size()) * 64'd8;
    padded = msg_bytes;
    padded.push_back(8'h80);
    while (padded.size() % 64 != 56) padded.push_back(8'h00);
    for (int i = 7; i >= 0; i--) padded.push_back(bl[8*i +: 8]);
  endfunction

  function automatic logic [511:0] exp_block(input int b);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[511-8*i -: 8] = padded[64*b+i];
    return r;
  endfunction

  task automatic run_msg(input int gap_pct, input int rdy_delay, input bit noise);
    int len, nblk, ptr, cycles, want_ptr;
    logic [511:0] held;
    len = msg_bytes.size();
    ptr = 0;
    build_model();
    nblk = padded.size() / 64;
    got_blocks.delete();
    @(negedge clk);
    start = 1'b1; msg_len = len;
    @(negedge clk);
    start = 1'b0; msg_len = $urandom;
    got_block_cnt = block;
    ntotal++; if (busy !== 1'b1) begin nbad++; $display("FAIL start_busy: got %b want 1", busy); end
    ntotal++; if (block !== 64'(nblk)) begin nbad++; $display("FAIL block_count: got %0d want %0d", block, nblk); end
    ntotal++; if (in_ready !== (len > 0)) begin nbad++; $display("FAIL first_ready: got %b want %b", in_ready, len > 0); end
    for (int b = 0; b < nblk; b++) begin
      cycles = 0;
      while (blk_valid !== 1'b1 && cycles < 4000) begin
        in_valid = ($urandom_range(99) >= gap_pct);
        in_data  = (ptr < len) ? msg_bytes[ptr] : 8'($urandom);
        if (noise) begin
          next_block_read_rdy = ($urandom_range(9) == 0);
          start   = ($urandom_range(9) == 0);
          msg_len = $urandom;
        end
        ntotal++;
        if (in_ready === 1'b1 && ptr >= len) begin
          nbad++; $display("FAIL extra_accept: got in_ready=1 at byte %0d want 0 (len %0d)", ptr, len);
        end
        if (in_valid && in_ready === 1'b1) ptr++;
        @(negedge clk);
        in_valid = 1'b0; next_block_read_rdy = 1'b0; start = 1'b0;
        cycles++;
      end
      ntotal++;
      if (blk_valid !== 1'b1) begin
        nbad++; $display("FAIL blk_timeout: got blk_valid=%b want 1 for block %0d", blk_valid, b);
        return;
      end
      if (gap_pct == 0) begin
        ntotal++; if (cycles != 64) begin nbad++; $display("FAIL fill_cycles: got %0d want 64", cycles); end
      end
      want_ptr = (64*(b+1) < len) ? 64*(b+1) : len;
      ntotal++; if (ptr != want_ptr) begin nbad++; $display("FAIL bytes_taken: got %0d want %0d", ptr, want_ptr); end
      ntotal++; if (message !== exp_block(b)) begin nbad++; $display("FAIL block_data %0d: got %h want %h", b, message, exp_block(b)); end
      got_blocks.push_back(message);
      held = message;
      for (int k = 0; k < rdy_delay; k++) begin
        in_valid = 1'b1; in_data = 8'($urandom);
        if (noise) begin start = ($urandom_range(3) == 0); msg_len = $urandom; end
        ntotal++; if (in_ready !== 1'b0) begin nbad++; $display("FAIL hold_ready: got %b want 0", in_ready); end
        ntotal++; if (blk_valid !== 1'b1) begin nbad++; $display("FAIL hold_valid: got %b want 1", blk_valid); end
        ntotal++; if (message !== held) begin nbad++; $display("FAIL hold_stable: got %h want %h", message, held); end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
      end
      next_block_read_rdy = 1'b1;
      @(negedge clk);
      next_block_read_rdy = 1'b0;
      ntotal++; if (blk_valid !== 1'b0) begin nbad++; $display("FAIL valid_drop: got %b want 0", blk_valid); end
      if (b == nblk - 1) begin
        ntotal++; if (done !== 1'b1) begin nbad++; $display("FAIL done_pulse: got %b want 1", done); end
        ntotal++; if (busy !== 1'b1) begin nbad++; $display("FAIL done_busy: got %b want 1", busy); end
        @(negedge clk);
        ntotal++; if (done !== 1'b0) begin nbad++; $display("FAIL done_clear: got %b want 0", done); end
        ntotal++; if (busy !== 1'b0) begin nbad++; $display("FAIL busy_clear: got %b want 0", busy); end
      end else begin
        ntotal++; if (done !== 1'b0) begin nbad++; $display("FAIL early_done: got %b want 0", done); end
        ntotal++; if (busy !== 1'b1) begin nbad++; $display("FAIL mid_busy: got %b want 1", busy); end
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    ntotal++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        message !== 512'd0 || block !== 64'd0) begin
      nbad++;
      $display("FAIL %s: got rdy=%b vld=%b busy=%b done=%b block=%0d msg_nonzero=%b want all 0",
               tag, in_ready, blk_valid, busy, done, block, message != 512'd0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    rst = 1'b0;
  endtask

  task automatic test_abc();
    msg_bytes = '{8'h61, 8'h62, 8'h63};
    run_msg(0, 3, 1'b0);
    ntotal++; if (got_block_cnt !== 64'd1) begin nbad++; $display("FAIL abc_block: got %0d want 1", got_block_cnt); end
    ntotal++;
    if (got_blocks[0] !== {32'h61626380, 416'd0, 64'h18}) begin
      nbad++; $display("FAIL abc_message: got %h want 61626380..18", got_blocks[0]);
    end
  endtask

  task automatic test_len0();
    msg_bytes.delete();
    run_msg(0, 0, 1'b0);
    ntotal++; if (got_block_cnt !== 64'd1) begin nbad++; $display("FAIL len0_block: got %0d want 1", got_block_cnt); end
    ntotal++; if (got_blocks[0] !== {8'h80, 504'd0}) begin nbad++; $display("FAIL len0_message: got %h want 80 then zeros", got_blocks[0]); end
  endtask

  task automatic test_len56();
    msg_bytes.delete();
    for (int i = 0; i < 56; i++) msg_bytes.push_back(8'(i));
    run_msg(0, 2, 1'b0);
    ntotal++; if (got_block_cnt !== 64'd2) begin nbad++; $display("FAIL len56_block: got %0d want 2", got_block_cnt); end
    ntotal++; if (got_blocks[0][63:0] !== 64'h8000_0000_0000_0000) begin nbad++; $display("FAIL len56_tail: got %h want 8000000000000000", got_blocks[0][63:0]); end
    ntotal++; if (got_blocks[0][511:480] !== 32'h00010203) begin nbad++; $display("FAIL len56_head: got %h want 00010203", got_blocks[0][511:480]); end
    ntotal++; if (got_blocks[1] !== {448'd0, 64'h1C0}) begin nbad++; $display("FAIL len56_final: got %h want zeros then 1c0", got_blocks[1]); end
  endtask

  task automatic test_len64();
    msg_bytes.delete();
    for (int i = 0; i < 64; i++) msg_bytes.push_back(8'($urandom));
    run_msg(0, 1, 1'b0);
    ntotal++; if (got_block_cnt !== 64'd2) begin nbad++; $display("FAIL len64_block: got %0d want 2", got_block_cnt); end
    ntotal++; if (got_blocks[1] !== {8'h80, 440'd0, 64'h200}) begin nbad++; $display("FAIL len64_final: got %h want 80..200", got_blocks[1]); end
  endtask

  task automatic test_stalls();
    msg_bytes.delete();
    for (int i = 0; i < 70; i++) msg_bytes.push_back(8'($urandom));
    run_msg(40, 20, 1'b1);
    ntotal++; if (got_block_cnt !== 64'd2) begin nbad++; $display("FAIL stall_block: got %0d want 2", got_block_cnt); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; msg_len = 32'd100;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid_values");
    rst = 1'b0;
    test_abc();
  endtask

  task automatic test_random();
    for (int m = 0; m < 4; m++) begin
      msg_bytes.delete();
      for (int i = 0; i < int'($urandom_range(200)); i++) msg_bytes.push_back(8'($urandom));
      run_msg(25, int'($urandom_range(5)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_len0();
    test_len56();
    test_len64();
    test_stalls();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule
